key_debounce: RTL

//  Input-side counterpart of the LED blink drivers: conditions one raw push-button for the detonator FSM.

---
 rtl/key_pkg.sv | 16 +
 rtl/sync_2ff.sv | 32 +++
 rtl/key_debounce.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button input path.
// Default timings assume the 125 MHz system clock.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_state_t;

    localparam int unsigned KEY_DB_20MS        = 32'd2_500_000;
    localparam int unsigned KEY_REP_START_0S5  = 32'd62_500_000;
    localparam int unsigned KEY_REP_PERIOD_0S1 = 32'd12_500_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// RST_VAL sets the value both flops take on reset.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronise, debounce, emit level and press/release strobes.
// Hold auto-repeat strobes are built only when KEY_REPEAT_EN is defined.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DB_CNT_MAX    = KEY_DB_20MS,
    parameter int unsigned REPEAT_START  = KEY_REP_START_0S5,
    parameter int unsigned REPEAT_PERIOD = KEY_REP_PERIOD_0S1,
    parameter bit          ACTIVE_HIGH   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    if (DB_CNT_MAX == 0 || REPEAT_START == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
        $error("key_debounce: timing parameters must be >= 1");
    end

    localparam logic [31:0] DB_LAST = 32'(DB_CNT_MAX - 1);

    logic key_norm;
    logic key_sync;

    // After this XOR, 1 always means pressed regardless of board wiring.
    assign key_norm = key_in ^ ~ACTIVE_HIGH;

    sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_norm),
        .q   (key_sync)
    );

    key_state_t  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        db_done;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        level_q, level_d;

    assign db_done = (cnt_q == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!key_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (db_done) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
            end
            RELEASE_DB: begin
                if (key_sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (db_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes fire on the edge that completes a debounce; the level follows one cycle later.
    always_comb begin
        press_d   = (state_q == PRESS_DB) && key_sync && db_done;
        release_d = (state_q == RELEASE_DB) && !key_sync && db_done;
        level_d   = level_q;
        if (press_q) begin
            level_d = 1'b1;
        end else if (release_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            level_q   <= level_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] REP_START_LAST  = 32'(REPEAT_START - 1);
    localparam logic [31:0] REP_PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        rep_phase_q, rep_phase_d;
    logic        repeat_q, repeat_d;
    logic        hold_hit;

    // rep_phase selects between the initial delay and the steady repeat period.
    assign hold_hit = (hold_cnt_q == (rep_phase_q ? REP_PERIOD_LAST : REP_START_LAST));

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        rep_phase_d = rep_phase_q;
        repeat_d    = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d  = '0;
                rep_phase_d = 1'b0;
            end
            HELD: begin
                if (hold_hit) begin
                    hold_cnt_d  = '0;
                    rep_phase_d = 1'b1;
                    repeat_d    = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: begin
                // Bounce in RELEASE_DB holds the schedule where it is.
                hold_cnt_d = hold_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            rep_phase_q <= rep_phase_d;
            repeat_q    <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
